// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the redirect priority encoding and the word-alignment helper.
package if_fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        REDIR_NONE = 3'd0,
        REDIR_TRAP = 3'd1,
        REDIR_MRET = 3'd2,
        REDIR_BR   = 3'd3,
        REDIR_WFI  = 3'd4
    } redir_e;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } fetch_state_e;

    // Highest-priority control event wins: trap > MRET > flush > WFI.
    function automatic redir_e redir_select(input logic trap, input logic mret,
                                            input logic flush, input logic wfi);
        redir_e r;
        if (trap) begin
            r = REDIR_TRAP;
        end else if (mret) begin
            r = REDIR_MRET;
        end else if (flush) begin
            r = REDIR_BR;
        end else if (wfi) begin
            r = REDIR_WFI;
        end else begin
            r = REDIR_NONE;
        end
        return r;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// In-order fetch buffer: slots are allocated at grant, filled in order by
// responses, and popped from the head. A fill landing on the head bypasses.
module if_fetch_buf
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          alloc,
    input  logic [31:0]   alloc_pc,
    input  logic          fill,
    input  logic [31:0]   fill_data,
    input  logic          pop,
    output logic          head_valid,
    output logic [31:0]   head_pc,
    output logic [31:0]   head_instr,
    output logic [CW-1:0] filled_cnt
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      pc_d    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      instr_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fill_hits_head_s;

    // Head view, including same-cycle bypass of a response filling the head.
    always_comb begin
        fill_hits_head_s = fill && valid_q[rd_ptr_q] && !filled_q[rd_ptr_q]
                           && (fill_ptr_q == rd_ptr_q);
        head_valid = valid_q[rd_ptr_q] && (filled_q[rd_ptr_q] || fill_hits_head_s);
        head_pc    = pc_q[rd_ptr_q];
        if (filled_q[rd_ptr_q]) begin
            head_instr = instr_q[rd_ptr_q];
        end else begin
            head_instr = fill_data;
        end
        filled_cnt = cnt_q;
    end

    // Slot bookkeeping; pop is applied last so a bypassed head is freed.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        filled_d   = filled_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        cnt_d      = cnt_q;
        if (clear) begin
            valid_d    = {DEPTH{1'b0}};
            filled_d   = {DEPTH{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
            wr_ptr_d   = {PW{1'b0}};
            fill_ptr_d = {PW{1'b0}};
            cnt_d      = {CW{1'b0}};
        end else begin
            if (alloc) begin
                pc_d[wr_ptr_q]     = alloc_pc;
                valid_d[wr_ptr_q]  = 1'b1;
                filled_d[wr_ptr_q] = 1'b0;
                wr_ptr_d           = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (fill) begin
                instr_d[fill_ptr_q]  = fill_data;
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = fill_ptr_q + PW'(1);
            end else begin
                fill_ptr_d = fill_ptr_q;
            end
            if (pop) begin
                valid_d[rd_ptr_q]  = 1'b0;
                filled_d[rd_ptr_q] = 1'b0;
                rd_ptr_d           = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            cnt_d = cnt_q + CW'(fill) - CW'(pop);
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= 32'h0000_0000;
                instr_q[i] <= NOP_INSTR;
            end
            valid_q    <= {DEPTH{1'b0}};
            filled_q   <= {DEPTH{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            fill_ptr_q <= {PW{1'b0}};
            cnt_q      <= {CW{1'b0}};
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            filled_q   <= filled_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generation, req/gnt + in-order response
// handling, redirects (trap/MRET/flush/WFI) with stale-response dropping.
module if_fetch_unit
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] br_target,
    input  logic        MRET,
    input  logic [31:0] mepc,
    input  logic        trap,
    input  logic [31:0] mtvec,
    input  logic        WFI,
    input  logic [31:0] wfi_pc,
    input  logic        irq_pending,
    output logic [31:0] PC_out,
    output logic [31:0] instruction_out,
    output logic        waiting
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;

    redir_e        redir_s;
    logic          redir_act_s;
    logic [31:0]   redir_tgt_s;
    logic [CW-1:0] filled_cnt_s;
    logic [CW-1:0] occ_s;
    logic          req_s, grant_s, rsp_any_s, rsp_drop_s, rsp_fill_s, pop_s, show_s;
    logic          head_valid_s;
    logic [31:0]   head_pc_s, head_instr_s;

    // Redirect selection and target.
    always_comb begin
        redir_s     = redir_select(trap, MRET, flush, WFI);
        redir_act_s = (redir_s != REDIR_NONE);
        case (redir_s)
            REDIR_TRAP: redir_tgt_s = word_align(mtvec);
            REDIR_MRET: redir_tgt_s = word_align(mepc);
            REDIR_BR:   redir_tgt_s = word_align(br_target);
            REDIR_WFI:  redir_tgt_s = word_align(wfi_pc);
            default:    redir_tgt_s = fetch_pc_q;
        endcase
    end

    // Handshake decode; rst gates req so nothing is requested while held in reset.
    always_comb begin
        occ_s      = filled_cnt_s + out_q;
        req_s      = rst && (state_q == ST_RUN) && !redir_act_s && (occ_s < CW'(DEPTH));
        grant_s    = req_s && imem_gnt;
        rsp_any_s  = imem_rvalid && ((drop_q != CW'(0)) || (out_q != CW'(0)));
        rsp_drop_s = imem_rvalid && (drop_q != CW'(0));
        rsp_fill_s = imem_rvalid && (drop_q == CW'(0)) && (out_q != CW'(0)) && !redir_act_s;
        show_s     = head_valid_s && (state_q == ST_RUN);
        pop_s      = show_s && !stall && !redir_act_s;
    end

    // Next-state: redirect overrides normal issue/response bookkeeping.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        if (redir_act_s) begin
            fetch_pc_d = redir_tgt_s;
            out_d      = CW'(0);
            drop_d     = drop_q + out_q - CW'(rsp_any_s);
            if (redir_s == REDIR_WFI) begin
                state_d = ST_SLEEP;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            if (grant_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_drop_s) begin
                drop_d = drop_q - CW'(1);
            end else begin
                drop_d = drop_q;
            end
            out_d = out_q + CW'(grant_s) - CW'(rsp_fill_s);
            if ((state_q == ST_SLEEP) && irq_pending) begin
                state_d = ST_RUN;
            end else begin
                state_d = state_q;
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            out_q      <= {CW{1'b0}};
            drop_q     <= {CW{1'b0}};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    if_fetch_buf #(.DEPTH(DEPTH), .CW(CW)) u_buf (
        .clk        (clk),
        .rst_n      (rst),
        .clear      (redir_act_s),
        .alloc      (grant_s),
        .alloc_pc   (fetch_pc_q),
        .fill       (rsp_fill_s),
        .fill_data  (imem_rdata),
        .pop        (pop_s),
        .head_valid (head_valid_s),
        .head_pc    (head_pc_s),
        .head_instr (head_instr_s),
        .filled_cnt (filled_cnt_s)
    );

    // IF/ID-facing outputs are zero whenever no valid instruction is presented.
    always_comb begin
        imem_req  = req_s;
        imem_addr = fetch_pc_q;
        waiting   = !show_s;
        if (show_s) begin
            PC_out          = head_pc_s;
            instruction_out = head_instr_s;
        end else begin
            PC_out          = 32'h0000_0000;
            instruction_out = NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: vector table for streaming/stall, plus
// hand sequences for flush, redirect priority, WFI, PC wrap and async reset.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall, flush, MRET, trap, WFI, irq_pending;
    logic [31:0] br_target, mepc, mtvec, wfi_pc;
    logic [31:0] PC_out, instruction_out;
    logic        waiting;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush), .br_target(br_target),
        .MRET(MRET), .mepc(mepc), .trap(trap), .mtvec(mtvec),
        .WFI(WFI), .wfi_pc(wfi_pc), .irq_pending(irq_pending),
        .PC_out(PC_out), .instruction_out(instruction_out), .waiting(waiting)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_wait;
        logic [31:0] exp_pc;
    } vec_t;

    pend_t pend[$];
    vec_t  tbl[10];
    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc   = 0;
    int    lat   = 1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic chk_vec(input int i);
        logic [31:0] exp_instr;
        exp_instr = tbl[i].exp_wait ? 32'h0000_0000 : instr_of(tbl[i].exp_pc);
        n_vec++;
        if (imem_req !== tbl[i].exp_req || imem_addr !== tbl[i].exp_addr ||
            waiting !== tbl[i].exp_wait || PC_out !== tbl[i].exp_pc ||
            instruction_out !== exp_instr) begin
            n_bad++;
            $display("FAIL vec%0d: got req=%b addr=%h wait=%b pc=%h ins=%h, expected req=%b addr=%h wait=%b pc=%h ins=%h",
                     i, imem_req, imem_addr, waiting, PC_out, instruction_out,
                     tbl[i].exp_req, tbl[i].exp_addr, tbl[i].exp_wait, tbl[i].exp_pc, exp_instr);
        end
    endtask

    task automatic set_idle();
        stall = 1'b0; flush = 1'b0; MRET = 1'b0; trap = 1'b0; WFI = 1'b0;
        irq_pending = 1'b0; imem_gnt = 1'b1;
        br_target = 32'h0; mepc = 32'h0; mtvec = 32'h0; wfi_pc = 32'h0;
    endtask

    task automatic drive_mem();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0000_0000;
        end
    endtask

    // Ends the current cycle: record a grant, cross the edge, present responses.
    task automatic step();
        pend_t p;
        if (imem_req && imem_gnt) begin
            p.addr = imem_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_mem();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_idle();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0000_0000;
        pend.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        //            stall req  addr          wait  pc
        tbl[0] = '{1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0004};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_000C, 1'b0, 32'h0000_0004};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_000C, 1'b0, 32'h0000_0004};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_000C, 1'b0, 32'h0000_0004};
        tbl[6] = '{1'b0, 1'b0, 32'h0000_000C, 1'b0, 32'h0000_0004};
        tbl[7] = '{1'b0, 1'b1, 32'h0000_000C, 1'b0, 32'h0000_0008};
        tbl[8] = '{1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_000C};
        tbl[9] = '{1'b0, 1'b1, 32'h0000_0014, 1'b0, 32'h0000_0010};

        rst = 1'b0;
        set_idle();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0000_0000;
        #2;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0000_0000);
        chk("rst_wait", 32'(waiting), 32'd1);
        chk("rst_pc", PC_out, 32'h0000_0000);
        chk("rst_instr", instruction_out, 32'h0000_0000);

        // Streaming and stall with a full buffer.
        do_reset();
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            stall = tbl[i].stall;
            #1;
            chk_vec(i);
            step();
        end

        // Flush with two requests outstanding: stale responses dropped.
        do_reset();
        lat = 3;
        #1; chk("fl_c0_addr", imem_addr, 32'h0000_0000); step();
        #1; chk("fl_c1_addr", imem_addr, 32'h0000_0004); step();
        flush = 1'b1; br_target = 32'h0000_0100;
        #1; chk("fl_redir_req", 32'(imem_req), 32'd0); step();
        set_idle();
        #1; chk("fl_new_addr", imem_addr, 32'h0000_0100);
        chk("fl_new_req", 32'(imem_req), 32'd1);
        chk("fl_c3_wait", 32'(waiting), 32'd1); step();
        #1; chk("fl_c4_wait", 32'(waiting), 32'd1); step();
        #1; chk("fl_c5_wait", 32'(waiting), 32'd1); step();
        #1; chk("fl_first_pc", PC_out, 32'h0000_0100);
        chk("fl_first_wait", 32'(waiting), 32'd0);
        chk("fl_first_instr", instruction_out, instr_of(32'h0000_0100)); step();
        lat = 1;

        // Priority: trap beats flush, MRET beats flush, target alignment.
        do_reset();
        trap = 1'b1; mtvec = 32'h0000_0080; flush = 1'b1; br_target = 32'h0000_0100;
        #1; chk("tr_redir_req", 32'(imem_req), 32'd0); step();
        set_idle();
        #1; chk("tr_addr", imem_addr, 32'h0000_0080);
        chk("tr_req", 32'(imem_req), 32'd1); step();
        MRET = 1'b1; mepc = 32'h0000_0203; flush = 1'b1; br_target = 32'h0000_0100;
        #1; chk("mr_redir_req", 32'(imem_req), 32'd0); step();
        set_idle();
        #1; chk("mr_addr", imem_addr, 32'h0000_0200);
        chk("mr_wait", 32'(waiting), 32'd1); step();

        // WFI sleep and wake on irq_pending.
        do_reset();
        WFI = 1'b1; wfi_pc = 32'h0000_0020;
        #1; chk("wfi_redir_req", 32'(imem_req), 32'd0); step();
        set_idle();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("wfi_sleep_req", 32'(imem_req), 32'd0);
            chk("wfi_sleep_wait", 32'(waiting), 32'd1);
            step();
        end
        irq_pending = 1'b1;
        #1; chk("wfi_irq_req", 32'(imem_req), 32'd0); step();
        irq_pending = 1'b0;
        #1; chk("wfi_wake_req", 32'(imem_req), 32'd1);
        chk("wfi_wake_addr", imem_addr, 32'h0000_0020); step();

        // PC wrap, then asynchronous reset mid-burst.
        do_reset();
        flush = 1'b1; br_target = 32'hFFFF_FFFC;
        #1; step();
        set_idle();
        #1; chk("wr_top_addr", imem_addr, 32'hFFFF_FFFC); step();
        #1; chk("wr_wrap_addr", imem_addr, 32'h0000_0000);
        chk("wr_wrap_pc", PC_out, 32'hFFFF_FFFC); step();
        #1; chk("wr_burst_pc", PC_out, 32'h0000_0000);
        chk("wr_burst_wait", 32'(waiting), 32'd0);
        #1; rst = 1'b0;
        #1;
        chk("ar_wait", 32'(waiting), 32'd1);
        chk("ar_pc", PC_out, 32'h0000_0000);
        chk("ar_instr", instruction_out, 32'h0000_0000);
        chk("ar_req", 32'(imem_req), 32'd0);
        chk("ar_addr", imem_addr, 32'h0000_0000);
        imem_rvalid = 1'b0;
        pend.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end. Generates the PC, issues requests to instruction memory with a request/grant plus response handshake, and buffers returned words.
- Presents PC/instruction pairs to the IF/ID pipeline register, together with the waiting indication that register consumes.
- Applies redirects for branch flush, MRET, trap and WFI, which are the same control events the IF/ID register reacts to.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, fetch-buffer entries, which is also the maximum number of outstanding requests (power of 2, minimum 2).

Ports:
- clk in 1: the single clock.
- rst in 1: asynchronous active-low reset.
- imem_req out 1: request valid.
- imem_addr out 32: request address, word aligned.
- imem_gnt in 1: request accepted this cycle.
- imem_rvalid in 1: response data valid. Responses return in order.
- imem_rdata in 32: response data.
- stall in 1: hazard unit holds IF/ID. The buffer head is not consumed.
- flush in 1: branch/jump taken. Redirect to br_target.
- br_target in 32: branch target.
- MRET in 1: return. Redirect to mepc.
- mepc in 32: return address.
- trap in 1: interrupt/exception. Redirect to mtvec.
- mtvec in 32: trap vector.
- WFI in 1: enter sleep. Resume address is wfi_pc.
- wfi_pc in 32: PC following the WFI instruction.
- irq_pending in 1: wake source while sleeping.
- PC_out out 32: PC to IF/ID.
- instruction_out out 32: instruction to IF/ID.
- waiting out 1: no valid instruction this cycle. IF/ID holds.

Behaviour:
Reset (asynchronous, rst=0):
- fetch_pc = RESET_PC; buffer empty; outstanding = 0; drop_cnt = 0; state RUN.
- imem_req = 0, imem_addr = RESET_PC, PC_out = 0, instruction_out = 0, waiting = 1.
- Reset asserted mid-transaction discards everything. Responses that arrive after reset release belong to the previous request stream and must not occur; the memory is reset from the same rst.

States:
- RUN: fetching.
- SLEEP: WFI accepted, no requests issued.

Request issue:
- In RUN, imem_req = 1 when (buffer count + outstanding) < DEPTH and no redirect is active this cycle.
- On imem_req & imem_gnt: allocate a buffer slot tagged with fetch_pc, outstanding+1, fetch_pc += 4 (32-bit wrap: 32'hFFFF_FFFC + 4 = 0).
- imem_addr = fetch_pc. It is stable while imem_req=1 and gnt=0.

Response:
- On imem_rvalid with drop_cnt > 0: decrement drop_cnt and discard the data.
- On imem_rvalid with drop_cnt = 0: fill the oldest unfilled slot and decrement outstanding.

Output:
- PC_out/instruction_out are combinational from the buffer head when the head is filled. waiting = 0 in that case.
- Otherwise waiting = 1 and PC_out/instruction_out = 0.
- Head pops when the head is filled and stall = 0. Best-case latency: gnt in cycle N, rvalid in N+1, instruction visible at the output in N+1.

Redirect:
- Priority is trap > MRET > flush > WFI; only the highest-priority event applies. Alignment: target[1:0] is forced to 0.
- In the redirect cycle:
  - Invalidate all buffer slots.
  - drop_cnt += outstanding, minus 1 if an rvalid is consumed that cycle.
  - outstanding = 0.
  - fetch_pc = target.
  - imem_req = 0.
  - waiting = 1 from the next cycle until new data returns.
- A grant that coincides with a redirect is not issued, because req is already 0.
- trap, MRET or flush while in SLEEP also sets state RUN.

WFI:
- Flush as above, fetch_pc = wfi_pc, state SLEEP.
- In SLEEP: imem_req = 0 and waiting = 1. Responses in flight are dropped via drop_cnt.
- irq_pending = 1 in SLEEP sets RUN in the next cycle, fetching from wfi_pc. If trap is asserted in the same cycle, trap wins.

Simultaneous stall and redirect: the redirect wins and the buffer is cleared.

Boundaries:
- Full (count + outstanding = DEPTH): no request.
- Empty: waiting = 1.
- drop_cnt never exceeds DEPTH.

Decomposition:
- Shared package holds NOP/zero instruction constant, RESET_PC default, and redirect-priority encoding enum (REDIR_NONE, REDIR_TRAP, REDIR_MRET, REDIR_BR, REDIR_WFI).
- One sub-module: if_fetch_buf, a DEPTH-entry in-order buffer storing {pc, instr, filled} with alloc/fill/pop/clear ports.

Test Plan:
- Reset release with gnt=1 and 1-cycle rvalid: addresses 0x0, 0x4, 0x8 issued back-to-back; PC_out/instruction_out follow in order; waiting=0 from the first response cycle.
- stall=1 for 3 cycles with buffer full: imem_req=0, PC_out held at 0x4, no entry lost; release gives 0x4 then 0x8.
- flush with br_target=0x100 while 2 requests are outstanding: both stale responses dropped; next imem_addr=0x100; first PC_out=0x100 and never 0x8.
- trap (mtvec=0x80) and flush (0x100) in the same cycle: next imem_addr=0x80.
- WFI with wfi_pc=0x20: imem_req=0 and waiting=1 for 10 cycles; irq_pending pulse gives imem_addr=0x20 one cycle later.
- fetch_pc=0xFFFF_FFFC, then grant: next imem_addr=0x0; async reset mid-burst gives outputs 0/waiting=1 immediately, without waiting for a clock edge.
